// File: rtl/user_strm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : user_strm_pkg
// Description : Shared interrupt FSM encoding and default loopback constants.
// Revision    : 1.0 - initial release
// ============================================================================
package user_strm_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 64;
   localparam int unsigned DEF_FIFO_DEPTH  = 16;
   localparam int unsigned DEF_INTR_THRESH = 256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACKD = 2'd2
   } intr_state_e;

endpackage
`default_nettype wire

// File: rtl/user_strm_fifo.sv
`default_nettype none
// ============================================================================
// Module      : user_strm_fifo
// Description : Synchronous power-of-two FIFO with registered level count.
// Revision    : 1.0 - initial release
// ============================================================================
module user_strm_fifo
   import user_strm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_wr_valid,
   output logic                          o_wr_ready,
   input  logic [DATA_WIDTH-1:0]         i_wr_data,
   output logic                          o_rd_valid,
   input  logic                          i_rd_ready,
   output logic [DATA_WIDTH-1:0]         o_rd_data,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  rdy_q, rdy_d;
   logic                  push, pop;

   // Ready comes from the registered level, so a pop while full frees the
   // slot for writers only on the following cycle.
   assign o_wr_ready = rdy_q && (level_q < LW'(FIFO_DEPTH));
   assign o_rd_valid = (level_q != '0);
   assign o_rd_data  = mem_q[rd_ptr_q];
   assign o_level    = level_q;

   always_comb begin
      push     = i_wr_valid && o_wr_ready;
      pop      = o_rd_valid && i_rd_ready;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);
      rdy_d    = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         rdy_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         rdy_q    <= rdy_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/user_strm_loopback.sv
`default_nettype none
// ============================================================================
// Module      : user_strm_loopback
// Description : Host stream loopback through a FIFO with word-count interrupt.
//               Optional macro USER_STRM_SWAP_EN swaps output data halves.
// Revision    : 1.0 - initial release
// ============================================================================
module user_strm_loopback
   import user_strm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int unsigned INTR_THRESH = DEF_INTR_THRESH
) (
   input  logic                          i_user_clk,
   input  logic                          i_rst_n,
   input  logic                          i_str_data_valid,
   output logic                          o_str_ack,
   input  logic [DATA_WIDTH-1:0]         i_str_data,
   output logic                          o_str_data_valid,
   input  logic                          i_str_ack,
   output logic [DATA_WIDTH-1:0]         o_str_data,
   output logic                          o_intr_req,
   input  logic                          i_intr_ack,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic [31:0]                   o_word_cnt
);

   localparam logic [31:0] THRESH = 32'(INTR_THRESH);

   logic [DATA_WIDTH-1:0] fifo_data;
   intr_state_e           state_q, state_d;
   logic [31:0]           word_cnt_q, word_cnt_d;
   logic [31:0]           sent_q, sent_d;
   logic [31:0]           sent_inc;
   logic                  pop;

   user_strm_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (i_user_clk),
      .i_rst_n    (i_rst_n),
      .i_wr_valid (i_str_data_valid),
      .o_wr_ready (o_str_ack),
      .i_wr_data  (i_str_data),
      .o_rd_valid (o_str_data_valid),
      .i_rd_ready (i_str_ack),
      .o_rd_data  (fifo_data),
      .o_level    (o_fifo_level)
   );

`ifdef USER_STRM_SWAP_EN
   assign o_str_data = {fifo_data[DATA_WIDTH/2-1:0], fifo_data[DATA_WIDTH-1:DATA_WIDTH/2]};
`else
   assign o_str_data = fifo_data;
`endif

   assign o_word_cnt = word_cnt_q;
   assign o_intr_req = (state_q == ST_REQ);

   // Threshold is tested against the post-pop count so the request is
   // visible the cycle right after the pop that reaches it.
   always_comb begin
      pop        = o_str_data_valid && i_str_ack;
      word_cnt_d = word_cnt_q + 32'(pop);
      sent_inc   = sent_q + 32'(pop);
      sent_d     = sent_inc;
      state_d    = state_q;
      case (state_q)
         ST_IDLE: begin
            if ((THRESH != 32'd0) && (sent_inc >= THRESH)) begin
               state_d = ST_REQ;
               sent_d  = '0;
            end
         end
         ST_REQ: begin
            if (i_intr_ack) state_d = ST_ACKD;
         end
         ST_ACKD: begin
            if (!i_intr_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_user_clk) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         word_cnt_q <= '0;
         sent_q     <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         sent_q     <= sent_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_user_strm_loopback.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_strm_loopback
// Description : Self-checking bench: vector table, directed corners, random
//               traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_strm_loopback;

   localparam int THR   = 4;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_v = 1'b0;
   logic [63:0] in_d = '0;
   logic        out_ack = 1'b0;
   logic        iack = 1'b0;
   logic        s_ack, s_v, s_intr;
   logic [63:0] s_d;
   logic [4:0]  s_lvl;
   logic [31:0] s_wc;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [63:0] mq[$];
   bit          m_rdy = 0, m_req = 0, m_ackd = 0;
   int unsigned m_wc = 0, m_sent = 0;
   bit          e_ack, e_valid;

   always #5 clk = ~clk;

   user_strm_loopback #(.DATA_WIDTH(64), .FIFO_DEPTH(DEPTH), .INTR_THRESH(THR)) dut (
      .i_user_clk       (clk),
      .i_rst_n          (rst_n),
      .i_str_data_valid (in_v),
      .o_str_ack        (s_ack),
      .i_str_data       (in_d),
      .o_str_data_valid (s_v),
      .i_str_ack        (out_ack),
      .o_str_data       (s_d),
      .o_intr_req       (s_intr),
      .i_intr_ack       (iack),
      .o_fifo_level     (s_lvl),
      .o_word_cnt       (s_wc)
   );

   function automatic logic [63:0] sw(input logic [63:0] x);
`ifdef USER_STRM_SWAP_EN
      return {x[31:0], x[63:32]};
`else
      return x;
`endif
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Compare all outputs with the model, away from the rising edge.
   task automatic sample();
      @(negedge clk);
      e_ack   = m_rdy && (mq.size() < DEPTH);
      e_valid = (mq.size() > 0);
      chk("ack", s_ack, e_ack);
      chk("valid", s_v, e_valid);
      chk("level", s_lvl, mq.size());
      chk("word_cnt", s_wc, m_wc);
      chk("intr_req", s_intr, m_req);
      if (e_valid) chk("data", s_d, sw(mq[0]));
   endtask

   task automatic advance();
      bit push, pop;
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_rdy = 0; m_req = 0; m_ackd = 0; m_wc = 0; m_sent = 0;
      end else begin
         push = in_v && e_ack;
         pop  = e_valid && out_ack;
         if (pop) begin
            void'(mq.pop_front());
            m_wc++;
            m_sent++;
         end
         if (push) mq.push_back(in_d);
         if (m_req) begin
            if (iack) begin m_req = 0; m_ackd = 1; end
         end else if (m_ackd) begin
            if (!iack) m_ackd = 0;
         end else if (THR != 0 && m_sent >= THR) begin
            m_req  = 1;
            m_sent = 0;
         end
         m_rdy = 1;
      end
      #1;
   endtask

   task automatic do_reset();
      in_v = 0; out_ack = 0; iack = 0; rst_n = 0;
      sample(); advance();
      rst_n = 1;
      sample(); advance();
   endtask

   // Send n words with the outbound side always ready; stops after n pops.
   task automatic send_words(input int n);
      int pushed = 0, pops = 0;
      for (int c = 0; c < 4 * n + 8 && pops < n; c++) begin
         in_v = (pushed < n); in_d = {32'hC0DE_0000 | 32'(c), $urandom}; out_ack = 1;
         sample();
         if (in_v && e_ack) pushed++;
         if (e_valid) pops++;
         advance();
      end
      in_v = 0;
      chk("send_words_done", 64'(pops), 64'(n));
   endtask

   typedef struct {
      bit rst_n; bit v; logic [63:0] d; bit ack;
      bit e_ack; bit e_valid; logic [63:0] e_data; int e_level; int e_wc;
   } vec_t;

   vec_t tv[5];

   initial begin
      tv[0] = '{0, 0, 64'h0, 1, 0, 0, 64'h0, 0, 0};
      tv[1] = '{1, 1, 64'h0123456789ABCDEF, 1, 0, 0, 64'h0, 0, 0};
      tv[2] = '{1, 1, 64'h0123456789ABCDEF, 1, 1, 0, 64'h0, 0, 0};
      tv[3] = '{1, 0, 64'h0, 1, 1, 1, 64'h0123456789ABCDEF, 1, 0};
      tv[4] = '{1, 0, 64'h0, 1, 1, 0, 64'h0, 0, 1};

      // bring the DUT out of X before any comparison
      rst_n = 0;
      @(posedge clk); @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         rst_n = tv[i].rst_n; in_v = tv[i].v; in_d = tv[i].d; out_ack = tv[i].ack;
         sample();
         chk("tv_ack", s_ack, tv[i].e_ack);
         chk("tv_valid", s_v, tv[i].e_valid);
         chk("tv_level", s_lvl, tv[i].e_level);
         chk("tv_wc", s_wc, tv[i].e_wc);
         if (tv[i].e_valid) chk("tv_data", s_d, sw(tv[i].e_data));
         advance();
      end

      // fill to full with the outbound side stalled
      do_reset();
      for (int k = 0; k < 18; k++) begin
         in_v = 1; in_d = {32'hF111_0000 | 32'(k), 32'(k * 7)}; out_ack = 0;
         sample(); advance();
      end
      in_v = 0;
      sample();
      chk("full_level", s_lvl, 16);
      chk("full_ack", s_ack, 0);
      // pop while full: ack must stay low this cycle and rise the next
      out_ack = 1; in_v = 1;
      advance(); sample();
      chk("ack_after_full_pop", s_ack, 1);
      in_v = 0;
      for (int k = 0; k < 16; k++) begin advance(); sample(); end
      chk("drain_empty", s_v, 0);
      out_ack = 0;
      advance();

      // steady push/pop at level 5
      do_reset();
      for (int k = 0; k < 5; k++) begin
         in_v = 1; in_d = 64'hAAAA_0000_0000_0000 | 64'(k); out_ack = 0;
         sample(); advance();
      end
      for (int k = 0; k < 20; k++) begin
         in_v = 1; in_d = {$urandom, $urandom}; out_ack = 1;
         sample(); chk("pp_level5", s_lvl, 5); advance();
      end
      in_v = 0; out_ack = 0;

      // interrupt after exactly four returned words
      do_reset();
      send_words(THR);
      out_ack = 0;
      sample(); chk("intr_after_4th", s_intr, 1);
      iack = 1; advance();
      sample(); chk("intr_low_ackd", s_intr, 0);
      iack = 0; advance();
      sample(); chk("intr_idle", s_intr, 0); advance();

      // reset while busy: level 7 with interrupt pending
      send_words(THR);
      for (int k = 0; k < 7; k++) begin
         in_v = 1; in_d = {$urandom, $urandom}; out_ack = 0;
         sample(); advance();
      end
      in_v = 0;
      sample();
      chk("pre_rst_level", s_lvl, 7);
      chk("pre_rst_intr", s_intr, 1);
      rst_n = 0; advance();
      sample();
      chk("rst_level", s_lvl, 0);
      chk("rst_intr", s_intr, 0);
      chk("rst_valid", s_v, 0);
      rst_n = 1; advance();
      sample(); chk("ack_one_after_release", s_ack, 1); advance();

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst_n   = ($urandom_range(0, 299) != 0);
         in_v    = ($urandom_range(0, 99) < 60);
         in_d    = {$urandom, $urandom};
         out_ack = ($urandom_range(0, 99) < 50);
         iack    = ($urandom_range(0, 99) < 30);
         sample(); advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/user_strm_loopback.md
USER_STRM_LOOPBACK -- requirements
Module: user_strm_loopback

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of stream data.
REQ-002 Parameter FIFO_DEPTH, default 16, buffer depth in words; power of 2, minimum 2.
REQ-003 Parameter INTR_THRESH, default 256, number of returned words per interrupt; 0 disables interrupts.
REQ-004 i_user_clk  in  1  sole clock; all logic is rising-edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_str_data_valid  in  1  inbound (host-to-FPGA) word valid.
REQ-007 o_str_ack  out  1  inbound word accepted.
REQ-008 i_str_data  in  DATA_WIDTH  inbound word.
REQ-009 o_str_data_valid  out  1  outbound (FPGA-to-host) word valid.
REQ-010 i_str_ack  in  1  outbound word accepted by the switch.
REQ-011 o_str_data  out  DATA_WIDTH  outbound word.
REQ-012 o_intr_req  out  1  interrupt request to the switch.
REQ-013 i_intr_ack  in  1  interrupt acknowledge from the switch.
REQ-014 o_fifo_level  out  log2(FIFO_DEPTH)+1  current buffered word count.
REQ-015 o_word_cnt  out  32  total words returned since reset; wraps modulo 2^32.

Function
REQ-016 A transfer on either stream occurs only in a cycle where valid and ack are both high.
REQ-017 o_str_ack is high exactly when o_fifo_level < FIFO_DEPTH, independent of i_str_data_valid.
REQ-018 o_str_ack stays low when full, even in a cycle where a pop occurs. The freed slot becomes visible one cycle later.
REQ-019 o_str_data_valid is high exactly when o_fifo_level > 0.
REQ-020 o_str_data presents the oldest buffered word.
REQ-021 o_str_data and o_str_data_valid hold stable until popped.
REQ-022 Latency: a word accepted in cycle N is presented on o_str_data no earlier than N+1 and no later than N+1 when the FIFO was empty.
REQ-023 A simultaneous push and pop leaves o_fifo_level unchanged. Word order is strictly preserved.
REQ-024 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 o_word_cnt increments by 1 on each outbound transfer.
REQ-026 The interrupt FSM has three states: IDLE, REQ and ACKD.
REQ-027 The internal sent counter increments on each outbound transfer.
REQ-028 IDLE -> REQ when the sent counter reaches INTR_THRESH; the sent counter clears to 0 on that transition.
REQ-029 REQ: o_intr_req is high. REQ -> ACKD on the first cycle i_intr_ack is sampled high.
REQ-030 ACKD: o_intr_req is low. ACKD -> IDLE when i_intr_ack is sampled low.
REQ-031 The sent counter keeps counting in REQ and ACKD.
REQ-032 If the sent counter is at or above INTR_THRESH on return to IDLE, the FSM re-enters REQ on the next cycle.
REQ-033 With INTR_THRESH = 0, the FSM stays in IDLE and o_intr_req stays 0.

Reset
REQ-034 While i_rst_n is low at a clock edge, the block sets: pointers and o_fifo_level to 0, o_word_cnt to 0, sent counter to 0, FSM to IDLE, o_intr_req 0, o_str_data_valid 0, o_str_ack 0.
REQ-035 o_str_ack rises on the first cycle after i_rst_n returns high.
REQ-036 Reset mid-transfer discards all buffered words. No partial word is emitted after reset.
REQ-037 FIFO storage contents are not reset; o_str_data is don't-care while o_str_data_valid is 0.

Configuration
REQ-038 Macro USER_STRM_SWAP_EN, when defined, makes o_str_data the buffered word with its upper and lower DATA_WIDTH/2 halves exchanged.
REQ-039 When USER_STRM_SWAP_EN is undefined, o_str_data is the buffered word unmodified.
REQ-040 The USER_STRM_SWAP_EN swap is purely combinational and adds no latency.

Structure
REQ-041 Shared package user_strm_pkg holds the FSM state encoding (IDLE, REQ, ACKD) and the default constants for DATA_WIDTH, FIFO_DEPTH and INTR_THRESH.
REQ-042 The buffer is one sub-module, user_strm_fifo (synchronous FIFO, same clock and reset), instantiated once.
REQ-043 The interrupt FSM and counters reside in user_strm_loopback.

Verification
REQ-044 Single word: push 0x0123456789ABCDEF with i_str_ack=1 -> o_str_data_valid high next cycle.
REQ-045 Single word result: o_str_data is 0x0123456789ABCDEF, or 0x89ABCDEF01234567 with USER_STRM_SWAP_EN. o_word_cnt is 1.
REQ-046 Full: hold i_str_ack=0 and push continuously -> o_str_ack drops after 16 accepts; o_fifo_level is 16.
REQ-047 Drain after full: set i_str_ack=1 -> 16 words emerge in order, then o_str_data_valid is 0.
REQ-048 Simultaneous push/pop at level 5 for 20 cycles -> level stays 5; output sequence equals input order.
REQ-049 Interrupt: INTR_THRESH=4, send 4 words -> o_intr_req high the cycle after the 4th pop. Pulse i_intr_ack for 1 cycle -> o_intr_req low; FSM returns to IDLE after ack falls.
REQ-050 Reset mid-stream: assert i_rst_n=0 with level 7 and o_intr_req high -> next cycle level 0, o_intr_req 0, o_str_data_valid 0; o_str_ack 1 one cycle after release.
